// File: rtl/spike_step_scheduler.sv
// Steps the spike encoder through N encode and R rest timesteps per image presentation,
// gating each step on network readiness and policing the encoder valid window.
module spike_step_scheduler #(
    parameter int STEP_W  = 8,
    parameter int WORDS   = 144,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [STEP_W-1:0] i_num_steps,
    input  logic [STEP_W-1:0] i_num_rest,
    input  logic              i_abort,
    input  logic              i_net_ready,
    input  logic              i_enc_valid,
    output logic              o_run,
    output logic              o_rest_run,
    output logic [STEP_W-1:0] o_step_idx,
    output logic              o_phase,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);
    localparam int WIN_W = $clog2(WORDS + 2);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT, DONE} state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] num_steps_q, num_steps_d;
    logic [STEP_W-1:0] num_rest_q, num_rest_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              phase_q, phase_d;
    logic              error_q, error_d;
    logic              abort_q, abort_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic              abort_now;
    logic              pulse;
    logic [STEP_W-1:0] limit;
    logic              last_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            num_steps_q <= '0;
            num_rest_q  <= '0;
            step_q      <= '0;
            phase_q     <= 1'b0;
            error_q     <= 1'b0;
            abort_q     <= 1'b0;
            win_q       <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            num_steps_q <= num_steps_d;
            num_rest_q  <= num_rest_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            error_q     <= error_d;
            abort_q     <= abort_d;
            win_q       <= win_d;
            to_q        <= to_d;
        end
    end

    assign limit     = phase_q ? num_rest_q : num_steps_q;
    // Extra bit keeps the compare exact when the limit is the all-ones count.
    assign last_step = (({1'b0, step_q} + 1'b1) == {1'b0, limit});
    assign abort_now = abort_q | i_abort;

    always_comb begin
        state_d     = state_q;
        num_steps_d = num_steps_q;
        num_rest_d  = num_rest_q;
        step_d      = step_q;
        phase_d     = phase_q;
        error_d     = error_q;
        abort_d     = abort_q;
        win_d       = win_q;
        to_d        = to_q;
        pulse       = 1'b0;

        if (state_q != IDLE && state_q != DONE) begin
            abort_d = abort_now;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    num_steps_d = i_num_steps;
                    num_rest_d  = i_num_rest;
                    error_d     = 1'b0;
                    abort_d     = 1'b0;
                    step_d      = '0;
                    phase_d     = (i_num_steps == '0);
                    if (i_num_steps == '0 && i_num_rest == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // An abort arriving with ready suppresses the pulse.
                if (abort_now) begin
                    state_d = DONE;
                end else if (i_net_ready) begin
                    pulse   = 1'b1;
                    to_d    = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_enc_valid) begin
                    win_d   = WIN_W'(1);
                    state_d = WAIT_LO;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (i_enc_valid) begin
                    if (win_q != WIN_W'(WORDS + 1)) begin
                        win_d = win_q + 1'b1;
                    end
                end else begin
                    if (win_q != WIN_W'(WORDS)) begin
                        error_d = 1'b1;
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (abort_now) begin
                    state_d = DONE;
                end else if (!last_step) begin
                    step_d  = step_q + 1'b1;
                    state_d = ISSUE;
                end else if (!phase_q && num_rest_q != '0) begin
                    phase_d = 1'b1;
                    step_d  = '0;
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_run      = pulse & ~phase_q;
    assign o_rest_run = pulse & phase_q;
    assign o_step_idx = step_q;
    assign o_phase    = phase_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_error    = error_q;

endmodule

// File: tb/tb_spike_step_scheduler.sv
// Presentation-level bench: each scenario is planned as a cycle timeline from the step/window
// rules, then driven into the scheduler and compared cycle by cycle.
module tb_spike_step_scheduler;
    localparam int STEP_W  = 8;
    localparam int WORDS   = 144;
    localparam int TIMEOUT = 16;
    localparam int MAXC    = 2048;
    localparam int VW      = 6 + STEP_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_start = 1'b0;
    logic [STEP_W-1:0] i_num_steps = '0;
    logic [STEP_W-1:0] i_num_rest = '0;
    logic              i_abort = 1'b0;
    logic              i_net_ready = 1'b0;
    logic              i_enc_valid = 1'b0;
    logic              o_run, o_rest_run, o_phase, o_busy, o_done, o_error;
    logic [STEP_W-1:0] o_step_idx;

    always #5 clk = ~clk;

    spike_step_scheduler #(.STEP_W(STEP_W), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_num_steps(i_num_steps),
        .i_num_rest(i_num_rest), .i_abort(i_abort), .i_net_ready(i_net_ready),
        .i_enc_valid(i_enc_valid), .o_run(o_run), .o_rest_run(o_rest_run),
        .o_step_idx(o_step_idx), .o_phase(o_phase), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error)
    );

    // Planned stimulus and expected {run, rest_run, busy, done, error, phase, step_idx} per cycle
    bit                pl_start[MAXC], pl_ready[MAXC], pl_valid[MAXC], pl_abort[MAXC];
    logic [STEP_W-1:0] pl_ns[MAXC], pl_nr[MAXC];
    logic [VW-1:0]     pl_exp[MAXC];
    int                plan_len, plan_t0;
    int                hold_idx;
    bit                hold_phase, hold_err;

    int n_chk = 0, n_fail = 0;
    int run_cnt, rest_cnt, done_cnt, busy_cnt, run_cyc, done_cyc;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic put(input int c, input bit run, input bit rest, input bit busy,
                       input bit done, input bit err, input bit ph, input int idx);
        pl_exp[c] = {run, rest, busy, done, err, ph, STEP_W'(idx)};
    endtask

    // Steps are numbered globally: 0..n-1 encode, n..n+r-1 rest. A -1 disables an option.
    task automatic build_plan(input int n, input int r, input int to_step, input int bad_step,
                              input int bad_len, input int ab_win, input int ab_iss,
                              input int gap1);
        int  k, total, cur, w, p, dly, v0, len, nxt, done_c, ab_cyc, idx;
        bit  err, ph;
        for (int c = 0; c < MAXC; c++) begin
            pl_start[c] = 1'b0;
            pl_ready[c] = 1'($urandom % 2);
            pl_valid[c] = 1'b0;
            pl_abort[c] = ($urandom % 6 == 0);
            pl_ns[c]    = STEP_W'($urandom);
            pl_nr[c]    = STEP_W'($urandom);
        end
        plan_t0 = 2 + $urandom_range(0, 2);
        for (int c = 0; c <= plan_t0; c++) put(c, 0, 0, 0, 0, hold_err, hold_phase, hold_idx);
        pl_start[plan_t0] = 1'b1;
        pl_ns[plan_t0]    = STEP_W'(n);
        pl_nr[plan_t0]    = STEP_W'(r);

        err = 1'b0; k = 0; total = n + r; cur = plan_t0 + 1; ab_cyc = -1;
        ph = (n == 0); idx = 0; done_c = cur;
        if (total != 0) begin
            while (1) begin
                ph  = (k >= n);
                idx = ph ? k - n : k;
                w   = (k == 1 && gap1 > 0) ? gap1 : int'($urandom_range(0, 3));
                p   = cur + w;
                for (int c = cur; c < p; c++) begin
                    pl_ready[c] = 1'b0;
                    put(c, 0, 0, 1, 0, err, ph, idx);
                end
                pl_ready[p] = 1'b1;
                if (k == ab_iss) begin
                    ab_cyc = p;
                    put(p, 0, 0, 1, 0, err, ph, idx);
                    done_c = p + 1;
                    break;
                end
                put(p, !ph, ph, 1, 0, err, ph, idx);
                if (k == to_step) begin
                    for (int c = p + 1; c <= p + TIMEOUT; c++) put(c, 0, 0, 1, 0, err, ph, idx);
                    err    = 1'b1;
                    done_c = p + TIMEOUT + 1;
                    break;
                end
                dly = $urandom_range(1, TIMEOUT);
                v0  = p + dly;
                len = (k == bad_step) ? bad_len : WORDS;
                for (int c = p + 1; c <= v0 + len; c++) put(c, 0, 0, 1, 0, err, ph, idx);
                for (int c = v0; c < v0 + len; c++) pl_valid[c] = 1'b1;
                if (k == ab_win) ab_cyc = $urandom_range(p + 1, v0 + len - 1);
                nxt = v0 + len + 1;
                if (len != WORDS) err = 1'b1;
                put(nxt, 0, 0, 1, 0, err, ph, idx);
                k++;
                if (ab_cyc >= 0 || k == total) begin
                    done_c = nxt + 1;
                    break;
                end
                cur = nxt + 1;
            end
        end
        if (done_c + 4 >= MAXC) begin
            $display("FAIL plan_overflow: got %0d cycles, expected below %0d", done_c + 4, MAXC);
            $fatal(1, "plan does not fit");
        end
        // Start pulses while busy must be ignored; abort only matters where planned.
        for (int c = plan_t0 + 1; c < done_c; c++) begin
            pl_abort[c] = 1'b0;
            pl_start[c] = ($urandom % 8 == 0);
        end
        pl_start[done_c] = 1'($urandom % 2);
        if (ab_cyc >= 0) pl_abort[ab_cyc] = 1'b1;
        put(done_c, 0, 0, 1, 1, err, ph, idx);
        for (int c = done_c + 1; c <= done_c + 3; c++) put(c, 0, 0, 0, 0, err, ph, idx);
        plan_len   = done_c + 4;
        hold_idx   = idx;
        hold_phase = ph;
        hold_err   = err;
    endtask

    task automatic run_plan(input int lim);
        logic [VW-1:0] act;
        run_cnt = 0; rest_cnt = 0; done_cnt = 0; busy_cnt = 0; run_cyc = -1; done_cyc = -1;
        for (int c = 0; c < plan_len && c < lim; c++) begin
            @(posedge clk);
            #1;
            i_start     = pl_start[c];
            i_num_steps = pl_ns[c];
            i_num_rest  = pl_nr[c];
            i_abort     = pl_abort[c];
            i_net_ready = pl_ready[c];
            i_enc_valid = pl_valid[c];
            @(negedge clk);
            act = {o_run, o_rest_run, o_busy, o_done, o_error, o_phase, o_step_idx};
            n_chk++;
            if (act !== pl_exp[c]) begin
                n_fail++;
                $display("FAIL cycle_outputs c=%0d: got %b, expected %b (run,rest,busy,done,err,phase,idx)",
                         c, act, pl_exp[c]);
            end
            run_cnt  += int'(o_run);
            rest_cnt += int'(o_rest_run);
            done_cnt += int'(o_done);
            busy_cnt += int'(o_busy);
            if (o_run) run_cyc = c;
            if (o_done) done_cyc = c;
        end
        i_start = 1'b0; i_abort = 1'b0; i_enc_valid = 1'b0;
    endtask

    function automatic logic [VW-1:0] out_vec();
        return {o_run, o_rest_run, o_busy, o_done, o_error, o_phase, o_step_idx};
    endfunction

    initial begin
        int n, r, tot, to_s, bad_s, bad_l, ab_w, ab_i, vfirst;
        hold_idx = 0; hold_phase = 1'b0; hold_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(out_vec()), 0);
        reset = 1'b0;

        // N=3, R=0 clean run
        build_plan(3, 0, -1, -1, WORDS, -1, -1, 0);
        run_plan(MAXC);
        check("t1_runs", run_cnt, 3);
        check("t1_rests", rest_cnt, 0);
        check("t1_dones", done_cnt, 1);
        check("t1_last_idx", int'(o_step_idx), 2);
        check("t1_error", int'(o_error), 0);

        // N=2, R=2 with ready held low 10 cycles before the second run
        build_plan(2, 2, -1, -1, WORDS, -1, -1, 10);
        run_plan(MAXC);
        check("t2_runs", run_cnt, 2);
        check("t2_rests", rest_cnt, 2);
        check("t2_phase_end", int'(o_phase), 1);

        // N=0, R=0: straight to done
        build_plan(0, 0, -1, -1, WORDS, -1, -1, 0);
        run_plan(MAXC);
        check("t3_pulses", run_cnt + rest_cnt, 0);
        check("t3_done_latency", done_cyc - plan_t0, 1);
        check("t3_busy_cycles", busy_cnt, 1);

        // Valid never rises after the first run
        build_plan(2, 0, 0, -1, WORDS, -1, -1, 0);
        run_plan(MAXC);
        check("t4_runs", run_cnt, 1);
        check("t4_run_to_done", done_cyc - run_cyc, TIMEOUT + 1);
        check("t4_error", int'(o_error), 1);
        build_plan(1, 0, -1, -1, WORDS, -1, -1, 0);
        run_plan(MAXC);
        check("t4_error_cleared", int'(o_error), 0);

        // One window one word short
        build_plan(3, 0, -1, 1, WORDS - 1, -1, -1, 0);
        run_plan(MAXC);
        check("t5_runs", run_cnt, 3);
        check("t5_error", int'(o_error), 1);

        // Abort inside the step-1 window of N=5
        build_plan(5, 0, -1, -1, WORDS, 1, -1, 0);
        run_plan(MAXC);
        check("t6_runs", run_cnt, 2);
        check("t6_dones", done_cnt, 1);

        // Abort coinciding with ready at step 2
        build_plan(4, 1, -1, -1, WORDS, -1, 2, 0);
        run_plan(MAXC);
        check("abort_issue_runs", run_cnt, 2);
        check("abort_issue_rests", rest_cnt, 0);

        // Rest-only and all-ones step count
        build_plan(0, 2, -1, -1, WORDS, -1, -1, 0);
        run_plan(MAXC);
        check("rest_only_rests", rest_cnt, 2);
        build_plan(255, 0, -1, -1, WORDS, 2, -1, 0);
        run_plan(MAXC);
        check("n255_runs", run_cnt, 3);
        check("n255_idx", int'(o_step_idx), 2);

        for (int s = 0; s < 10; s++) begin
            n = $urandom_range(0, 4);
            r = $urandom_range(0, 3);
            tot = n + r;
            to_s = -1; bad_s = -1; ab_w = -1; ab_i = -1;
            if (tot > 0 && $urandom % 5 == 0) to_s = $urandom_range(0, tot - 1);
            if (tot > 0 && $urandom % 3 == 0) bad_s = $urandom_range(0, tot - 1);
            if (tot > 0 && $urandom % 5 == 0) ab_w = $urandom_range(0, tot - 1);
            if (tot > 0 && $urandom % 6 == 0) ab_i = $urandom_range(0, tot - 1);
            case ($urandom % 4)
                0: bad_l = WORDS - 1;
                1: bad_l = WORDS + 1;
                2: bad_l = 1;
                default: bad_l = WORDS + 20;
            endcase
            build_plan(n, r, to_s, bad_s, bad_l, ab_w, ab_i, 0);
            run_plan(MAXC);
        end

        // Asynchronous reset in the middle of a window
        build_plan(5, 2, -1, -1, WORDS, -1, -1, 0);
        vfirst = 0;
        while (vfirst < plan_len && !pl_valid[vfirst]) vfirst++;
        run_plan(vfirst + 30);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("midreset_outputs", int'(out_vec()), 0);
        @(negedge clk);
        check("midreset_hold", int'(out_vec()), 0);
        reset = 1'b0;
        hold_idx = 0; hold_phase = 1'b0; hold_err = 1'b0;
        build_plan(1, 1, -1, -1, WORDS, -1, -1, 0);
        run_plan(MAXC);
        check("post_reset_pulses", run_cnt + rest_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
